// File: rtl/fft_r2_sequencer_if.sv
// Op bus between the FFT sequencer and the shared butterfly/RAM datapath.
// The sequencer drives the op fields; the datapath returns op_ready and one wb_ack per retired op.
interface fft_r2_sequencer_if #(
    parameter int LOG2_NS = 3
);
    localparam int TW = (LOG2_NS > 1) ? LOG2_NS - 1 : 1;

    logic               op_valid;
    logic               op_ready;
    logic               op_swap;
    logic [LOG2_NS-1:0] addr_a;
    logic [LOG2_NS-1:0] addr_b;
    logic [TW-1:0]      tw_idx;
    logic               tw_conj;
    logic [LOG2_NS-1:0] stage;
    logic               wb_ack;

    modport master (
        output op_valid, op_swap, addr_a, addr_b, tw_idx, tw_conj, stage,
        input  op_ready, wb_ack
    );

    modport slave (
        input  op_valid, op_swap, addr_a, addr_b, tw_idx, tw_conj, stage,
        output op_ready, wb_ack
    );
endinterface

// File: rtl/fft_r2_sequencer.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT: one butterfly op per accepted handshake.
// Optional macro FFT_SEQ_BITREV_EN adds a bit-reverse swap pass (BITREV) ahead of stage 0.
module fft_r2_sequencer #(
    parameter int LOG2_NS = 3,
    parameter int NS      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic inverse,
    output logic busy,
    output logic done,
    fft_r2_sequencer_if.master op_if
);
    localparam int PW = LOG2_NS + 1;
    localparam int TW = (LOG2_NS > 1) ? LOG2_NS - 1 : 1;
    localparam logic [PW-1:0]      HALF_PTS   = PW'(NS / 2);
    localparam logic [LOG2_NS-1:0] LAST_STAGE = LOG2_NS'(LOG2_NS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BITREV  = 3'd1,
        S_BRDRAIN = 3'd2,
        S_RUN     = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

`ifdef FFT_SEQ_BITREV_EN
    localparam logic [PW-1:0] ALL_PTS     = PW'(NS);
    localparam state_t        FIRST_STATE = S_BITREV;
`else
    localparam state_t        FIRST_STATE = S_RUN;
`endif

    function automatic logic [LOG2_NS-1:0] bit_rev(input logic [LOG2_NS-1:0] v);
        logic [LOG2_NS-1:0] r;
        r = '0;
        for (int b = 0; b < LOG2_NS; b++) begin
            r[b] = v[LOG2_NS-1-b];
        end
        return r;
    endfunction

    // Upper-leg address: group g of width 2*half, offset j within the group.
    function automatic logic [LOG2_NS-1:0] bfly_addr_a(input logic [LOG2_NS-1:0] k,
                                                       input logic [LOG2_NS-1:0] s);
        logic [LOG2_NS-1:0] j;
        logic [LOG2_NS-1:0] g;
        j = k & ((LOG2_NS'(1) << s) - LOG2_NS'(1));
        g = k >> s;
        return (g << (s + LOG2_NS'(1))) + j;
    endfunction

    function automatic logic [TW-1:0] bfly_tw(input logic [LOG2_NS-1:0] k,
                                              input logic [LOG2_NS-1:0] s);
        logic [LOG2_NS-1:0] j;
        logic [LOG2_NS-1:0] t;
        j = k & ((LOG2_NS'(1) << s) - LOG2_NS'(1));
        t = j << (LOG2_NS'(LOG2_NS - 1) - s);
        return t[TW-1:0];
    endfunction

    state_t             state_r, next_state_s;
    logic [PW-1:0]      ptr_r, ptr_s;
    logic [LOG2_NS-1:0] ptr_k_s;
    logic [LOG2_NS-1:0] stage_r, stage_s;
    logic [PW-1:0]      outstanding_r;
    logic               conj_r;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               op_valid_r, op_valid_s;
    logic               op_swap_r, op_swap_s;
    logic [LOG2_NS-1:0] addr_a_r, addr_a_s;
    logic [LOG2_NS-1:0] addr_b_r, addr_b_s;
    logic [TW-1:0]      tw_idx_r, tw_idx_s;
    logic               accept_s;
    logic               slot_free_s;
    logic               drained_s;

    assign accept_s    = op_valid_r && op_if.op_ready;
    assign slot_free_s = !op_valid_r || op_if.op_ready;
    assign drained_s   = (outstanding_r == '0);
    assign ptr_k_s     = ptr_r[LOG2_NS-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a pass ends once its pointer is exhausted and the last op has left the slot.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) next_state_s = FIRST_STATE;
                else       next_state_s = S_IDLE;
            end
            S_BITREV: begin
`ifdef FFT_SEQ_BITREV_EN
                if ((ptr_r == ALL_PTS) && slot_free_s) next_state_s = S_BRDRAIN;
                else                                   next_state_s = S_BITREV;
`else
                next_state_s = S_IDLE;
`endif
            end
            S_BRDRAIN: begin
                if (drained_s) next_state_s = S_RUN;
                else           next_state_s = S_BRDRAIN;
            end
            S_RUN: begin
                if ((ptr_r == HALF_PTS) && slot_free_s) next_state_s = S_DRAIN;
                else                                    next_state_s = S_RUN;
            end
            S_DRAIN: begin
                if (!drained_s)                  next_state_s = S_DRAIN;
                else if (stage_r == LAST_STAGE)  next_state_s = S_DONE;
                else                             next_state_s = S_RUN;
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Output logic: next values of op fields, pass pointer and stage; fields are held while stalled.
    always_comb begin
        op_valid_s = op_valid_r;
        op_swap_s  = op_swap_r;
        addr_a_s   = addr_a_r;
        addr_b_s   = addr_b_r;
        tw_idx_s   = tw_idx_r;
        ptr_s      = ptr_r;
        stage_s    = stage_r;
        busy_s     = (next_state_s != S_IDLE) && (next_state_s != S_DONE);
        done_s     = (next_state_s == S_DONE);
        case (state_r)
            S_IDLE: begin
                ptr_s = '0;
                if (start) stage_s = '0;
                else       stage_s = stage_r;
            end
            S_BITREV: begin
`ifdef FFT_SEQ_BITREV_EN
                if (!slot_free_s) begin
                    op_valid_s = 1'b1;
                end else if (ptr_r == ALL_PTS) begin
                    op_valid_s = 1'b0;
                    ptr_s      = '0;
                end else begin
                    ptr_s = ptr_r + PW'(1);
                    // Each pair is swapped once, from its smaller index; the rest are skipped.
                    if (ptr_k_s < bit_rev(ptr_k_s)) begin
                        op_valid_s = 1'b1;
                        op_swap_s  = 1'b1;
                        addr_a_s   = ptr_k_s;
                        addr_b_s   = bit_rev(ptr_k_s);
                        tw_idx_s   = '0;
                    end else begin
                        op_valid_s = 1'b0;
                    end
                end
`else
                op_valid_s = 1'b0;
                ptr_s      = '0;
`endif
            end
            S_RUN: begin
                if (!slot_free_s) begin
                    op_valid_s = 1'b1;
                end else if (ptr_r == HALF_PTS) begin
                    op_valid_s = 1'b0;
                    ptr_s      = '0;
                end else begin
                    ptr_s      = ptr_r + PW'(1);
                    op_valid_s = 1'b1;
                    op_swap_s  = 1'b0;
                    addr_a_s   = bfly_addr_a(ptr_k_s, stage_r);
                    addr_b_s   = bfly_addr_a(ptr_k_s, stage_r) + (LOG2_NS'(1) << stage_r);
                    tw_idx_s   = bfly_tw(ptr_k_s, stage_r);
                end
            end
            S_DRAIN: begin
                op_valid_s = 1'b0;
                ptr_s      = '0;
                if (drained_s && (stage_r != LAST_STAGE)) stage_s = stage_r + LOG2_NS'(1);
                else                                      stage_s = stage_r;
            end
            default: begin
                op_valid_s = 1'b0;
                ptr_s      = '0;
            end
        endcase
    end

    // Output and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            op_valid_r <= 1'b0;
            op_swap_r  <= 1'b0;
            addr_a_r   <= '0;
            addr_b_r   <= '0;
            tw_idx_r   <= '0;
            ptr_r      <= '0;
            stage_r    <= '0;
        end else begin
            busy_r     <= busy_s;
            done_r     <= done_s;
            op_valid_r <= op_valid_s;
            op_swap_r  <= op_swap_s;
            addr_a_r   <= addr_a_s;
            addr_b_r   <= addr_b_s;
            tw_idx_r   <= tw_idx_s;
            ptr_r      <= ptr_s;
            stage_r    <= stage_s;
        end
    end

    // Ops in flight in the datapath; a stray writeback with nothing outstanding is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= '0;
        end else begin
            case ({accept_s, op_if.wb_ack})
                2'b10:   outstanding_r <= outstanding_r + PW'(1);
                2'b01:   outstanding_r <= drained_s ? outstanding_r : outstanding_r - PW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Transform direction, latched only when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            conj_r <= 1'b0;
        end else if ((state_r == S_IDLE) && start) begin
            conj_r <= inverse;
        end else begin
            conj_r <= conj_r;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign op_if.op_valid = op_valid_r;
    assign op_if.op_swap  = op_swap_r;
    assign op_if.addr_a   = addr_a_r;
    assign op_if.addr_b   = addr_b_r;
    assign op_if.tw_idx   = tw_idx_r;
    assign op_if.tw_conj  = conj_r;
    assign op_if.stage    = stage_r;
endmodule

// File: tb/tb_fft_r2_sequencer.sv
// Randomized self-checking bench for fft_r2_sequencer: a list-based model of the expected op
// stream plus a single compare process; honours FFT_SEQ_BITREV_EN when defined.
module tb_fft_r2_sequencer;
    localparam int L  = 3;
    localparam int NS = 8;
`ifdef FFT_SEQ_BITREV_EN
    localparam int BR_OPS = 2;
`else
    localparam int BR_OPS = 0;
`endif
    localparam int TOTAL = BR_OPS + 12;

    logic clk = 1'b0;
    logic rst, start, inverse, busy, done;
    fft_r2_sequencer_if #(.LOG2_NS(L)) bus ();

    fft_r2_sequencer #(.LOG2_NS(L), .NS(NS)) dut (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse),
        .busy(busy), .done(done), .op_if(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int exp_q[$];
    bit exp_conj = 1'b0;
    bit chk_en = 1'b0;
    int tb_out = 0, last_phase = -5, prev_fields = 0;
    bit prev_stall = 1'b0, prev_done = 1'b0;
    int done_cnt = 0, acc_cnt = 0;
    bit saw_s1 = 1'b0;
    int first_s1_cyc = -1, delayed_ack_cyc = -1;
    bit ready_rand = 1'b0, ack_rand = 1'b0, delay_s0 = 1'b0;
    int due_q[$];
    bit tag_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pack(input int sw, input int s, input int a, input int b, input int tw);
        return (sw << 24) | (s << 18) | (a << 12) | (b << 6) | tw;
    endfunction

    // Expected op stream: optional bit-reverse swaps, then every butterfly group of every stage.
    task automatic build_expected();
        exp_q.delete();
`ifdef FFT_SEQ_BITREV_EN
        for (int i = 0; i < NS; i++) begin
            int r;
            r = 0;
            for (int b = 0; b < L; b++) if ((i >> b) & 1) r = r | (1 << (L - 1 - b));
            if (i < r) exp_q.push_back(pack(1, 0, i, r, 0));
        end
`endif
        for (int s = 0; s < L; s++) begin
            int half;
            half = 1 << s;
            for (int base = 0; base < NS; base += 2 * half)
                for (int j = 0; j < half; j++)
                    exp_q.push_back(pack(0, s, base + j, base + j + half, j * (NS / (2 * half))));
        end
    endtask

    // Datapath stand-in: random op_ready, one wb_ack per accepted op after a latency.
    initial begin
        bus.op_ready = 1'b0;
        bus.wb_ack   = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.op_valid && bus.op_ready) begin
                int lat;
                bit dly;
                lat = ack_rand ? int'($urandom_range(1, 4)) : 2;
                dly = delay_s0 && !bus.op_swap && (int'(bus.stage) == 0) && (int'(bus.addr_a) == NS - 2);
                due_q.push_back(cyc + lat + (dly ? 10 : 0));
                tag_q.push_back(dly);
            end
            @(posedge clk);
            cyc++;
            #1;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                bus.wb_ack = 1'b1;
                if (tag_q[0]) delayed_ack_cyc = cyc;
                void'(due_q.pop_front());
                void'(tag_q.pop_front());
            end else begin
                bus.wb_ack = 1'b0;
            end
            bus.op_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Compare process: every cycle checks stall hold, stage barrier, op order/content and done.
    always @(negedge clk) begin
        if (chk_en) begin
            int cur;
            int ph;
            cur = pack(bus.op_swap, bus.stage, bus.addr_a, bus.addr_b, bus.tw_idx);
            if (prev_stall) begin
                check("stall_valid", bus.op_valid, 1);
                check("stall_hold", cur, prev_fields);
            end
            if (bus.op_valid) begin
                ph = bus.op_swap ? -1 : int'(bus.stage);
                check("busy_with_op", busy, 1);
                if (ph != last_phase) check("stage_barrier_outstanding", tb_out, 0);
                if (!bus.op_swap && int'(bus.stage) == 1) begin
                    saw_s1 = 1'b1;
                    if (first_s1_cyc < 0) first_s1_cyc = cyc;
                end
                if (bus.op_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_op", exp_q.size(), 1);
                    end else begin
                        check("op_fields", cur, exp_q.pop_front());
                        check("tw_conj", bus.tw_conj, exp_conj);
                    end
                    acc_cnt++;
                    last_phase = ph;
                end
            end
            if (bus.op_valid && bus.op_ready && !bus.wb_ack) tb_out++;
            else if (!(bus.op_valid && bus.op_ready) && bus.wb_ack && tb_out > 0) tb_out--;
            if (done) begin
                check("done_all_retired", exp_q.size() + tb_out, 0);
                check("busy_low_at_done", busy, 0);
                check("done_single_cycle", prev_done, 0);
                done_cnt++;
            end
            prev_stall  = bus.op_valid && !bus.op_ready;
            prev_fields = cur;
            prev_done   = done;
        end else begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            tb_out     = 0;
            last_phase = -5;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_ctrl"}, {27'd0, busy, done, bus.op_valid, bus.op_swap, bus.tw_conj}, 0);
        check({tag, "_fields"}, pack(0, bus.stage, bus.addr_a, bus.addr_b, bus.tw_idx), 0);
    endtask

    task automatic run_fft(input bit inv, input bit stray);
        bit timed_out;
        build_expected();
        exp_conj = inv;
        done_cnt = 0;
        acc_cnt  = 0;
        timed_out = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; inverse = inv;
        @(posedge clk); #1;
        start = 1'b0; inverse = 1'b0;
        check("busy_after_start", busy, 1);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (done_cnt != 0) begin
                start = 1'b0;
                timed_out = 1'b0;
                break;
            end
            start   = stray && (i % 7 == 3);
            inverse = start ? !inv : 1'b0;
        end
        start = 1'b0; inverse = 1'b0;
        if (timed_out) check("done_timeout", done_cnt, 1);
        repeat (5) @(posedge clk);
        #1;
        check("done_count", done_cnt, 1);
        check("idle_after_done", busy, 0);
        check("ops_issued", acc_cnt, TOTAL);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; inverse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        build_expected();
        check("model_total", exp_q.size(), TOTAL);
        check("model_s0_op2", exp_q[BR_OPS + 2], pack(0, 0, 4, 5, 0));
        check("model_s1_op1", exp_q[BR_OPS + 5], pack(0, 1, 1, 3, 2));
        check("model_s2_op3", exp_q[BR_OPS + 11], pack(0, 2, 3, 7, 3));
`ifdef FFT_SEQ_BITREV_EN
        check("model_swap0", exp_q[0], pack(1, 0, 1, 4, 0));
        check("model_swap1", exp_q[1], pack(1, 0, 3, 6, 0));
`endif
        chk_en = 1'b1;

        run_fft(1'b0, 1'b0);
        ready_rand = 1'b1; ack_rand = 1'b1;
        run_fft(1'b0, 1'b0);
        run_fft(1'b1, 1'b0);

        ready_rand = 1'b0; ack_rand = 1'b0; delay_s0 = 1'b1;
        first_s1_cyc = -1; delayed_ack_cyc = -1;
        run_fft(1'b0, 1'b0);
        delay_s0 = 1'b0;
        check("delayed_ack_seen", int'(delayed_ack_cyc >= 0), 1);
        check("s1_after_delayed_ack", int'(first_s1_cyc > delayed_ack_cyc), 1);

        ready_rand = 1'b1; ack_rand = 1'b1;
        run_fft(1'b1, 1'b1);

        build_expected();
        exp_conj = 1'b0; saw_s1 = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 500 && !saw_s1; i++) @(posedge clk);
        if (!saw_s1) check("stage1_timeout", saw_s1, 1);
        @(posedge clk); #1;
        chk_en = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midrun_reset");
        rst = 1'b0;
        for (int i = 0; i < 100 && due_q.size() > 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", {30'd0, busy, bus.op_valid}, 0);
        chk_en = 1'b1;
        run_fft(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
